ex_div_sequencer: RTL and testbench

//  Multi-cycle integer divider sequencer for the EX stage; executes div.w/mod.w/div.wu/mod.wu
//  (alu_op[15..18] from decode) with a radix-2 restoring datapath it owns and steps.
//  EX holds the instruction (ready_go=0) while busy; result goes to the EX result mux on resp handshake.

---
 rtl/ex_div_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_ex_div_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_sequencer.sv
// Multi-cycle radix-2 restoring divider sequencer for the EX stage (div.w/mod.w/div.wu/mod.wu).
// Optional macro DIV_EARLY_OUT_EN: skip the iteration phase when |dividend| < |divisor|.
module ex_div_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              qsign_q, qsign_d;
  logic              rsign_q, rsign_d;
  logic              valid_q, valid_d;

  logic              is_signed;
  logic              is_mod;
  logic              accept;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W:0]   trial;

  // op one-hot order is {mod_wu, div_wu, mod_w, div_w}
  assign is_signed = op_q[0] | op_q[1];
  assign is_mod    = op_q[1] | op_q[3];
  assign abs1      = (is_signed && src1_q[DATA_W-1]) ? -src1_q : src1_q;
  assign abs2      = (is_signed && src2_q[DATA_W-1]) ? -src2_q : src2_q;
  assign trial     = {rem_q, quo_q[DATA_W-1]};

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign resp_valid  = valid_q;
  assign resp_result = result_q;
  assign accept      = req_valid & req_ready & (req_op != 4'b0000) & ~flush;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    valid_d  = valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = req_op;
          src1_d  = req_src1;
          src2_d  = req_src2;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        qsign_d = is_signed & (src1_q[DATA_W-1] ^ src2_q[DATA_W-1]);
        rsign_d = is_signed & src1_q[DATA_W-1];
        dvs_d   = abs2;
        cnt_d   = '0;
        // Divide by zero bypasses sign fix-up: remainder is the raw dividend.
        if (src2_q == '0) begin
          quo_d   = '1;
          rem_d   = src1_q;
          state_d = S_DONE;
        end
`ifdef DIV_EARLY_OUT_EN
        else if (abs1 < abs2) begin
          quo_d   = '0;
          rem_d   = abs1;
          state_d = S_FIX;
        end
`endif
        else begin
          quo_d   = abs1;
          rem_d   = '0;
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        if (trial >= {1'b0, dvs_q}) begin
          rem_d = trial[DATA_W-1:0] - dvs_q;
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = trial[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_FIX: begin
        if (qsign_q) quo_d = -quo_q;
        if (rsign_q) rem_d = -rem_q;
        state_d = S_DONE;
      end

      S_DONE: begin
        // Result is published one cycle after entering DONE, then held until consumed.
        if (!valid_q) begin
          valid_d  = 1'b1;
          result_d = is_mod ? rem_q : quo_q;
        end else if (resp_ready) begin
          valid_d  = 1'b0;
          result_d = '0;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      result_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_ex_div_sequencer.sv
// Self-checking bench for ex_div_sequencer: transaction-level model plus directed and random ops.
module tb_ex_div_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_src1;
  logic [W-1:0] req_src2;
  logic         flush;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_result;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int edgeCount = 0;
  bit started = 0;

  bit           mBusy = 0;
  bit           mValid = 0;
  logic [W-1:0] mResult = '0;
  logic [W-1:0] mPend = '0;
  int           mRiseAt = 0;

  ex_div_sequencer #(.DATA_W(W), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] modelResult(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    longint sa, sb, q, r;
    bit sgn, isMod;
    sgn   = op[0] | op[1];
    isMod = op[1] | op[3];
    if (b == 0) return isMod ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return isMod ? r[31:0] : q[31:0];
  endfunction

  function automatic int expLat(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return 2;
`ifdef DIV_EARLY_OUT_EN
    begin
      longint ma, mb;
      bit sgn;
      sgn = op[0] | op[1];
      ma = {32'h0, a};
      mb = {32'h0, b};
      if (sgn && a[31]) ma = 64'h1_0000_0000 - ma;
      if (sgn && b[31]) mb = 64'h1_0000_0000 - mb;
      if (ma < mb) return 3;
    end
`endif
    return W + 3;
  endfunction

  // Reference: one op in flight; result appears a fixed number of edges after acceptance.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mBusy = 0;
      mValid = 0;
      mResult = '0;
    end else begin
      edgeCount++;
      if (flush) begin
        mBusy = 0;
        mValid = 0;
        mResult = '0;
      end else if (!mBusy) begin
        if (req_valid && req_op != 4'b0000) begin
          mBusy = 1;
          mPend = modelResult(req_op, req_src1, req_src2);
          mRiseAt = edgeCount + expLat(req_op, req_src1, req_src2);
        end
      end else if (mValid) begin
        if (resp_ready) begin
          mBusy = 0;
          mValid = 0;
          mResult = '0;
        end
      end else if (edgeCount == mRiseAt) begin
        mValid = 1;
        mResult = mPend;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checkOutput("cyc req_ready", 32'(req_ready), 32'(!mBusy));
      checkOutput("cyc busy", 32'(busy), 32'(mBusy));
      checkOutput("cyc resp_valid", 32'(resp_valid), 32'(mValid));
      checkOutput("cyc resp_result", resp_result, mResult);
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               output int acceptEdge);
    @(posedge clk); #1;
    req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
    @(posedge clk); #1;
    acceptEdge = edgeCount;
    req_valid = 0; req_op = 4'b0000;
  endtask

  task automatic waitValid(output int seenEdge);
    bit found;
    found = 0;
    seenEdge = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        found = 1;
        seenEdge = edgeCount;
      end
    end
  endtask

  task automatic handshake(input string name);
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    checkOutput({name, " released"}, 32'(resp_valid), 32'd0);
    checkOutput({name, " ready again"}, 32'(req_ready), 32'd1);
  endtask

  task automatic runOp(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] expRes, input int hold,
                       output int lat);
    int acceptEdge, seen;
    applyStimulus(op, a, b, acceptEdge);
    waitValid(seen);
    lat = (seen < 0) ? -1 : seen - acceptEdge;
    checkOutput({name, " latency"}, 32'(lat), 32'(expLat(op, a, b)));
    checkOutput({name, " result"}, resp_result, expRes);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    checkOutput({name, " held valid"}, 32'(resp_valid), 32'd1);
    checkOutput({name, " held result"}, resp_result, expRes);
    handshake(name);
  endtask

  initial begin
    int lat, acceptEdge, seen;
    bit sawValid;
    logic [3:0] op;
    logic [W-1:0] a, b;

    resetn = 0; req_valid = 0; req_op = 0; req_src1 = 0; req_src2 = 0;
    flush = 0; resp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset resp_result", resp_result, 32'd0);
    resetn = 1;
    started = 1;

    checkOutput("pin div_w 7/2", modelResult(4'b0001, 7, 2), 32'd3);
    checkOutput("pin mod_w -7/2", modelResult(4'b0010, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
    checkOutput("pin div_w -7/2", modelResult(4'b0001, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
    checkOutput("pin div_w ovf", modelResult(4'b0001, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    checkOutput("pin mod_wu 5/0", modelResult(4'b1000, 5, 0), 32'd5);
    checkOutput("pin lat full", 32'(expLat(4'b0001, 7, 2)), 32'd35);
    checkOutput("pin lat div0", 32'(expLat(4'b0001, 5, 0)), 32'd2);

    runOp("t1 div_w 7/2", 4'b0001, 7, 2, 32'd3, 3, lat);
    checkOutput("t1 latency literal", 32'(lat), 32'd35);
    runOp("t2 mod_w -7/2", 4'b0010, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 0, lat);
    runOp("t2 div_w -7/2", 4'b0001, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 1, lat);
    runOp("t3 div_wu", 4'b0100, 32'hFFFF_FFFF, 2, 32'h7FFF_FFFF, 0, lat);
    runOp("t3 mod_wu", 4'b1000, 32'hFFFF_FFFF, 2, 32'd1, 0, lat);
    runOp("t3 div_w ovf", 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, lat);
    runOp("t3 mod_w ovf", 4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, lat);
    runOp("t4 div_w 5/0", 4'b0001, 5, 0, 32'hFFFF_FFFF, 2, lat);
    checkOutput("t4 latency literal", 32'(lat), 32'd2);
    runOp("t4 mod_wu 5/0", 4'b1000, 5, 0, 32'd5, 0, lat);

    applyStimulus(4'b0001, 1000, 7, acceptEdge);
    repeat (11) @(posedge clk);
    #1; flush = 1;
    @(posedge clk); #1; flush = 0;
    checkOutput("t5 flush ready", 32'(req_ready), 32'd1);
    checkOutput("t5 flush busy", 32'(busy), 32'd0);
    sawValid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) sawValid = 1;
    end
    checkOutput("t5 no response", 32'(sawValid), 32'd0);
    runOp("t5 div_w 9/3", 4'b0001, 9, 3, 32'd3, 0, lat);

    applyStimulus(4'b0001, 12345, 17, acceptEdge);
    repeat (5) @(posedge clk);
    #2; resetn = 0;
    #1;
    checkOutput("t6 midreset req_ready", 32'(req_ready), 32'd1);
    checkOutput("t6 midreset busy", 32'(busy), 32'd0);
    checkOutput("t6 midreset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("t6 midreset resp_result", resp_result, 32'd0);
    @(posedge clk); #1; resetn = 1;
    runOp("t6 div_wu 3/10", 4'b0100, 3, 10, 32'd0, 1, lat);
`ifdef DIV_EARLY_OUT_EN
    checkOutput("t6 early latency literal", 32'(lat), 32'd3);
`else
    checkOutput("t6 full latency literal", 32'(lat), 32'd35);
`endif

    @(posedge clk); #1;
    req_valid = 1; req_op = 4'b0000; req_src1 = 5; req_src2 = 1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t7 op zero busy", 32'(busy), 32'd0);
    req_valid = 0;

    applyStimulus(4'b0010, 50, 7, acceptEdge);
    waitValid(seen);
    checkOutput("t9 result before flush", resp_result, 32'd1);
    flush = 1; resp_ready = 1;
    @(posedge clk); #1;
    flush = 0; resp_ready = 0;
    checkOutput("t9 flush wins valid", 32'(resp_valid), 32'd0);
    checkOutput("t9 flush wins result", resp_result, 32'd0);

    applyStimulus(4'b0001, 100, 7, acceptEdge);
    waitValid(seen);
    checkOutput("t8 first result", resp_result, 32'd14);
    resp_ready = 1; req_valid = 1; req_op = 4'b0100; req_src1 = 20; req_src2 = 6;
    @(posedge clk); #1;
    resp_ready = 0;
    checkOutput("t8 not accepted in DONE", 32'(busy), 32'd0);
    @(posedge clk); #1;
    acceptEdge = edgeCount;
    req_valid = 0; req_op = 4'b0000;
    checkOutput("t8 accepted next cycle", 32'(busy), 32'd1);
    waitValid(seen);
    checkOutput("t8 second latency", 32'((seen < 0) ? -1 : seen - acceptEdge), 32'd35);
    checkOutput("t8 second result", resp_result, 32'd3);
    handshake("t8");

    for (int n = 0; n < 30; n++) begin
      op = 4'b0001 << $urandom_range(0, 3);
      case ($urandom_range(0, 7))
        0: begin a = $urandom; b = 0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin
          a = $urandom_range(0, 50);
          b = $urandom_range(1, 60);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      runOp("rand", op, a, b, modelResult(op, a, b), $urandom_range(0, 3), lat);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
